eth_latency_coord: RTL and testbench
====================================

# eth_latency_coord

Parametrised ping/pong latency coordinator for the Ethernet latency measurer. It triggers a probe on the main interface and waits for it on the loopback interface. It then triggers the reply on the loopback interface and waits for it back on the main interface, timestamping both legs. Compared with the fixed-width coordinator it adds configurable counter/statistic widths, a bounded burst mode, running round-trip min/max/sum statistics and a synchronous statistics clear.

## Interface
Parameters:
- CNT_W, 32, width of delay/timeout/leg-time counters
- ID_W, 64, width of probe identifier
- STAT_W, 64, width of good/lost counters and rtt_sum

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run measurement; low forces delay restart
- stats_clear  in  1  one-cycle pulse, zeroes counters/statistics
- psize_req  in  16  payload size sampled at each probe launch
- delay_time  in  CNT_W  inter-probe gap, cycles
- timeout  in  CNT_W  per-leg timeout, cycles
- burst_len  in  32  probes per burst; 0 = continuous
- psize  out  16  latched payload size
- ping_id  out  ID_W  current probe id
- main_rx_ping_id, loop_rx_ping_id  in  ID_W  id last received on each interface
- main_tx_trigger, loop_tx_trigger  out  1  one-cycle launch pulses
- main_tx_begin, loop_tx_begin  in  1  transmitter started frame
- done  out  1  one-cycle pulse per finished probe
- ping_time, pong_time  out  CNT_W  last leg times; all-ones = lost
- ping_pongs_good, pings_lost, pongs_lost  out  STAT_W  totals
- rtt_min, rtt_max  out  CNT_W+1  extremes of ping_time+pong_time over good probes
- rtt_sum  out  STAT_W  saturating sum of good rtts
- burst_done  out  1  level; burst finished, waiting for enable low
- busy  out  1  level; state not ST_DELAY/ST_HOLD

## Operation
- States: ST_DELAY, ST_WAIT_PING_TX, ST_PING, ST_WAIT_PONG_TX, ST_PONG, ST_HOLD. Any illegal encoding returns to ST_DELAY.
- count increments every cycle unless a transition sets it.
- ST_DELAY:
  - enable low: count=1, burst counter=0.
  - enable high and count>=delay_time: latch psize=psize_req, pulse main_tx_trigger, go ST_WAIT_PING_TX.
- ST_WAIT_PING_TX: main_tx_begin → count=1, ST_PING.
- ST_PING:
  - loop_rx_ping_id==ping_id: ping_time=count, pulse loop_tx_trigger, count=1, ST_WAIT_PONG_TX.
  - Else count>=timeout: ping_time=pong_time='1, pings_lost+1, done.
  - The id match has priority over the timeout.
- ST_WAIT_PONG_TX: loop_tx_begin → count=1, ST_PONG.
- ST_PONG:
  - main_rx_ping_id==ping_id: pong_time=count, good+1, update rtt stats, done, ping_id+1.
  - Else timeout: pong_time='1, pongs_lost+1, done, ping_id+1.
- A lost ping does not advance ping_id; every pong outcome does.
- Each done: count=0, burst counter+1. Go ST_HOLD if burst_len≠0 and the new burst count equals burst_len, else ST_DELAY.
- ST_HOLD: burst_done=1. Leaves for ST_DELAY (count=1, burst counter=0) only when enable is low.
- RTT statistics:
  - rtt = ping_time_new + pong_time_new, zero-extended to CNT_W+1.
  - rtt_min = min(rtt_min, rtt); rtt_max = max(rtt_max, rtt).
  - rtt_sum saturates at all-ones.
- stats_clear:
  - Zeroes good/lost counters, rtt_max and rtt_sum; sets rtt_min all-ones. Does not touch state, ping_id or times.
  - If it coincides with a done, clear wins for the statistics; done and the time outputs still update.
- All counter wrap (ping_id, good/lost) is modulo 2^width; only rtt_sum saturates.

## Timing
- Reset values:
  - state ST_DELAY, count=1, psize=46, ping_id=0.
  - All triggers, done, burst_done and busy 0.
  - Times, counters, rtt_max and rtt_sum 0; rtt_min all-ones.
- All outputs are registered.
- Trigger pulses assert the cycle after the deciding state cycle and last one cycle.
- done and the updated times/counters/statistics become visible in the same cycle.
- Leg-time convention: a match on the first ST_PING cycle after main_tx_begin gives ping_time=1.
- Gap: first trigger after enable rises at count>=delay_time, so ≥delay_time cycles. Subsequent gaps are delay_time+1 cycles after done (count restarts at 0).
- Dropping enable mid-probe does not abort the probe; it completes or times out, then ST_DELAY holds.
- timeout=0 or 1 times out on the first cycle with no id match.
- rst mid-probe returns everything to reset values in the next cycle.

## Structure
- Package eth_latency_pkg: state enum, PSIZE_DEFAULT=46, and a function rtt_update(min,max,sum,rtt) returning the updated triple.
- Sub-module eth_latency_stats: registered min/max/saturating sum with clear and update inputs. Instantiated once.
- The FSM stays in the top module.

## Test plan
- Normal probe: delay_time=10, timeout=100, loop id matches 5 cycles after main_tx_begin, main id matches 7 cycles after loop_tx_begin → ping_time=5, pong_time=7, good=1, rtt_min=rtt_max=rtt_sum=12, ping_id=1.
- Lost ping: no loop match, timeout=20 → done after 20 cycles in ST_PING, times all-ones, pings_lost=1, ping_id unchanged.
- Lost pong: ping matches, pong never does → pongs_lost=1, ping_id+1, stats unchanged.
- Burst: burst_len=3, all good → exactly 3 done pulses, burst_done=1 with no further triggers; enable low then high → new burst starts.
- Stats: rtts 12, 4, 30 → min 4, max 30, sum 46. stats_clear in the same cycle as the 4th done → all statistics cleared, done still pulses.
- Saturation: STAT_W=8, rtt 200 twice → rtt_sum=255.

Source files
------------

// File: rtl/eth_latency_coord_pkg.sv
// Shared definitions for the Ethernet ping/pong latency coordinator.
// - state_t       : coordinator FSM states
// - PSIZE_DEFAULT : payload size held until the first probe launch
// - rtt_update()  : folds one round-trip time into the min/max/saturating-sum
//                   triple. It works at the widest supported widths
//                   (CNT_W <= 64, STAT_W <= 64); callers zero-extend their
//                   operands and truncate the result back.
package eth_latency_pkg;

  typedef enum logic [2:0] {
    ST_DELAY        = 3'd0,
    ST_WAIT_PING_TX = 3'd1,
    ST_PING         = 3'd2,
    ST_WAIT_PONG_TX = 3'd3,
    ST_PONG         = 3'd4,
    ST_HOLD         = 3'd5
  } state_t;

  localparam logic [15:0] PSIZE_DEFAULT = 16'd46;

  localparam int RTT_MAX_W = 65;
  localparam int SUM_MAX_W = 64;

  typedef logic [RTT_MAX_W-1:0] rtt_wide_t;
  typedef logic [SUM_MAX_W-1:0] sum_wide_t;

  typedef struct packed {
    rtt_wide_t rtt_min;
    rtt_wide_t rtt_max;
    sum_wide_t rtt_sum;
  } rtt_stats_t;

  // sum_limit is the all-ones value of the caller's real sum width, so the
  // saturation point follows STAT_W even though the math is done wide.
  function automatic rtt_stats_t rtt_update(input rtt_wide_t cur_min,
                                            input rtt_wide_t cur_max,
                                            input sum_wide_t cur_sum,
                                            input rtt_wide_t rtt,
                                            input sum_wide_t sum_limit);
    rtt_stats_t            res;
    logic [RTT_MAX_W:0]    total;
    res.rtt_min = (rtt < cur_min) ? rtt : cur_min;
    res.rtt_max = (rtt > cur_max) ? rtt : cur_max;
    total       = {2'b00, cur_sum} + {1'b0, rtt};
    res.rtt_sum = (total > {2'b00, sum_limit}) ? sum_limit : total[SUM_MAX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/eth_latency_coord_if.sv
// Probe link between the latency coordinator and the main/loopback
// transmitters and receivers.
// - main_tx_trigger / loop_tx_trigger : one-cycle launch pulses (coordinator)
// - ping_id                           : id carried by the current probe
// - main_tx_begin / loop_tx_begin     : transmitter started the frame
// - main_rx_ping_id / loop_rx_ping_id : id last received on each interface
interface eth_latency_coord_if #(
  parameter int ID_W = 64
);
  logic            main_tx_trigger;
  logic            loop_tx_trigger;
  logic [ID_W-1:0] ping_id;
  logic            main_tx_begin;
  logic            loop_tx_begin;
  logic [ID_W-1:0] main_rx_ping_id;
  logic [ID_W-1:0] loop_rx_ping_id;

  // Coordinator side
  modport master (
    output main_tx_trigger, loop_tx_trigger, ping_id,
    input  main_tx_begin, loop_tx_begin, main_rx_ping_id, loop_rx_ping_id
  );

  // Transceiver side
  modport slave (
    input  main_tx_trigger, loop_tx_trigger, ping_id,
    output main_tx_begin, loop_tx_begin, main_rx_ping_id, loop_rx_ping_id
  );
endinterface

// File: rtl/eth_latency_stats.sv
// Round-trip statistics registers: running minimum, maximum and a
// saturating sum of good round-trip times.
// - clk, rst : clock, synchronous active-high reset
// - clear    : zero max/sum, set min to all-ones (wins over upd)
// - upd      : fold rtt into the statistics this cycle
// - rtt      : round-trip time, CNT_W+1 bits
// - rtt_min, rtt_max, rtt_sum : registered statistics
module eth_latency_stats
  import eth_latency_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int STAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              upd,
  input  logic [CNT_W:0]    rtt,
  output logic [CNT_W:0]    rtt_min,
  output logic [CNT_W:0]    rtt_max,
  output logic [STAT_W-1:0] rtt_sum
);

  localparam logic [STAT_W-1:0] SUM_ONES = '1;

  logic [CNT_W:0]    min_q, min_d;
  logic [CNT_W:0]    max_q, max_d;
  logic [STAT_W-1:0] sum_q, sum_d;
  rtt_stats_t        upd_res;

  always_comb begin
    upd_res = rtt_update(rtt_wide_t'(min_q), rtt_wide_t'(max_q),
                         sum_wide_t'(sum_q), rtt_wide_t'(rtt),
                         sum_wide_t'(SUM_ONES));
    min_d = min_q;
    max_d = max_q;
    sum_d = sum_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
      sum_d = '0;
    end else if (upd) begin
      min_d = (CNT_W+1)'(upd_res.rtt_min);
      max_d = (CNT_W+1)'(upd_res.rtt_max);
      sum_d = STAT_W'(upd_res.rtt_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign rtt_min = min_q;
  assign rtt_max = max_q;
  assign rtt_sum = sum_q;

endmodule

// File: rtl/eth_latency_coord.sv
// Ping/pong latency coordinator. Launches a probe on the main interface,
// waits for it on the loopback interface (ping leg), launches the reply on
// the loopback interface and waits for it back on main (pong leg). Both leg
// times are reported per probe along with loss counters and round-trip
// min/max/sum statistics. An optional burst length stops launching after
// burst_len probes until enable is dropped.
// Ports:
// - clk, rst                  : clock, synchronous active-high reset
// - enable                    : run measurement; low restarts the gap
// - stats_clear               : zero counters/statistics
// - psize_req / psize         : payload size, latched at each launch
// - delay_time, timeout       : inter-probe gap and per-leg timeout (cycles)
// - burst_len                 : probes per burst, 0 = continuous
// - lnk                       : probe link (triggers, ping_id, begins, rx ids)
// - done                      : one-cycle pulse per finished probe
// - ping_time, pong_time      : last leg times, all-ones = lost
// - ping_pongs_good, pings_lost, pongs_lost : totals
// - rtt_min, rtt_max, rtt_sum : round-trip statistics over good probes
// - burst_done, busy          : status levels
module eth_latency_coord
  import eth_latency_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int ID_W   = 64,
  parameter int STAT_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                stats_clear,
  input  logic [15:0]         psize_req,
  input  logic [CNT_W-1:0]    delay_time,
  input  logic [CNT_W-1:0]    timeout,
  input  logic [31:0]         burst_len,
  eth_latency_coord_if.master lnk,
  output logic [15:0]         psize,
  output logic                done,
  output logic [CNT_W-1:0]    ping_time,
  output logic [CNT_W-1:0]    pong_time,
  output logic [STAT_W-1:0]   ping_pongs_good,
  output logic [STAT_W-1:0]   pings_lost,
  output logic [STAT_W-1:0]   pongs_lost,
  output logic [CNT_W:0]      rtt_min,
  output logic [CNT_W:0]      rtt_max,
  output logic [STAT_W-1:0]   rtt_sum,
  output logic                burst_done,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         burst_cnt_q, burst_cnt_d;
  logic [15:0]         psize_q, psize_d;
  logic [ID_W-1:0]     ping_id_q, ping_id_d;
  logic                main_trig_q, main_trig_d;
  logic                loop_trig_q, loop_trig_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    ping_time_q, ping_time_d;
  logic [CNT_W-1:0]    pong_time_q, pong_time_d;
  logic [STAT_W-1:0]   good_q, good_d;
  logic [STAT_W-1:0]   pings_lost_q, pings_lost_d;
  logic [STAT_W-1:0]   pongs_lost_q, pongs_lost_d;
  logic                burst_done_q, burst_done_d;
  logic                busy_q, busy_d;

  logic                finish;
  logic                stat_upd;
  logic                ping_match;
  logic                pong_match;
  logic [CNT_W:0]      rtt_new;

  assign ping_match = (lnk.loop_rx_ping_id == ping_id_q);
  assign pong_match = (lnk.main_rx_ping_id == ping_id_q);
  // Only meaningful in ST_PONG on a match: ping_time_q holds this probe's
  // ping leg and count_q is the pong leg being recorded this cycle.
  assign rtt_new    = {1'b0, ping_time_q} + {1'b0, count_q};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q + 1'b1;
    burst_cnt_d  = burst_cnt_q;
    psize_d      = psize_q;
    ping_id_d    = ping_id_q;
    main_trig_d  = 1'b0;
    loop_trig_d  = 1'b0;
    done_d       = 1'b0;
    ping_time_d  = ping_time_q;
    pong_time_d  = pong_time_q;
    good_d       = good_q;
    pings_lost_d = pings_lost_q;
    pongs_lost_d = pongs_lost_q;
    finish       = 1'b0;
    stat_upd     = 1'b0;

    case (state_q)
      ST_DELAY: begin
        if (!enable) begin
          count_d     = CNT_ONE;
          burst_cnt_d = '0;
        end else if (count_q >= delay_time) begin
          psize_d     = psize_req;
          main_trig_d = 1'b1;
          state_d     = ST_WAIT_PING_TX;
        end
      end
      ST_WAIT_PING_TX: begin
        if (lnk.main_tx_begin) begin
          count_d = CNT_ONE;
          state_d = ST_PING;
        end
      end
      ST_PING: begin
        // A match on the timeout cycle still counts as received.
        if (ping_match) begin
          ping_time_d = count_q;
          loop_trig_d = 1'b1;
          count_d     = CNT_ONE;
          state_d     = ST_WAIT_PONG_TX;
        end else if (count_q >= timeout) begin
          ping_time_d  = '1;
          pong_time_d  = '1;
          pings_lost_d = pings_lost_q + 1'b1;
          finish       = 1'b1;
        end
      end
      ST_WAIT_PONG_TX: begin
        if (lnk.loop_tx_begin) begin
          count_d = CNT_ONE;
          state_d = ST_PONG;
        end
      end
      ST_PONG: begin
        if (pong_match) begin
          pong_time_d = count_q;
          good_d      = good_q + 1'b1;
          stat_upd    = 1'b1;
          finish      = 1'b1;
          ping_id_d   = ping_id_q + 1'b1;
        end else if (count_q >= timeout) begin
          pong_time_d  = '1;
          pongs_lost_d = pongs_lost_q + 1'b1;
          finish       = 1'b1;
          ping_id_d    = ping_id_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          count_d     = CNT_ONE;
          burst_cnt_d = '0;
          state_d     = ST_DELAY;
        end
      end
      default: state_d = ST_DELAY;
    endcase

    // Common probe completion: count restarts at 0 so later gaps are
    // delay_time+1 cycles.
    if (finish) begin
      done_d      = 1'b1;
      count_d     = '0;
      burst_cnt_d = burst_cnt_q + 1'b1;
      state_d     = ((burst_len != '0) && (burst_cnt_d == burst_len)) ? ST_HOLD : ST_DELAY;
    end

    // Clear overrides any same-cycle increment.
    if (stats_clear) begin
      good_d       = '0;
      pings_lost_d = '0;
      pongs_lost_d = '0;
    end

    busy_d       = !(state_d inside {ST_DELAY, ST_HOLD});
    burst_done_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_DELAY;
      count_q      <= CNT_ONE;
      burst_cnt_q  <= '0;
      psize_q      <= PSIZE_DEFAULT;
      ping_id_q    <= '0;
      main_trig_q  <= 1'b0;
      loop_trig_q  <= 1'b0;
      done_q       <= 1'b0;
      ping_time_q  <= '0;
      pong_time_q  <= '0;
      good_q       <= '0;
      pings_lost_q <= '0;
      pongs_lost_q <= '0;
      burst_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      burst_cnt_q  <= burst_cnt_d;
      psize_q      <= psize_d;
      ping_id_q    <= ping_id_d;
      main_trig_q  <= main_trig_d;
      loop_trig_q  <= loop_trig_d;
      done_q       <= done_d;
      ping_time_q  <= ping_time_d;
      pong_time_q  <= pong_time_d;
      good_q       <= good_d;
      pings_lost_q <= pings_lost_d;
      pongs_lost_q <= pongs_lost_d;
      burst_done_q <= burst_done_d;
      busy_q       <= busy_d;
    end
  end

  eth_latency_stats #(
    .CNT_W  (CNT_W),
    .STAT_W (STAT_W)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .clear   (stats_clear),
    .upd     (stat_upd),
    .rtt     (rtt_new),
    .rtt_min (rtt_min),
    .rtt_max (rtt_max),
    .rtt_sum (rtt_sum)
  );

  assign lnk.main_tx_trigger = main_trig_q;
  assign lnk.loop_tx_trigger = loop_trig_q;
  assign lnk.ping_id         = ping_id_q;
  assign psize               = psize_q;
  assign done                = done_q;
  assign ping_time           = ping_time_q;
  assign pong_time           = pong_time_q;
  assign ping_pongs_good     = good_q;
  assign pings_lost          = pings_lost_q;
  assign pongs_lost          = pongs_lost_q;
  assign burst_done          = burst_done_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_eth_latency_coord.sv
// Bench for eth_latency_coord: a driver plays the main/loopback transceivers,
// a probe-level model predicts each probe's outcome and queues it, and a
// monitor compares the DUT outputs on every done pulse.
module tb_eth_latency_coord;

  localparam int CNT_W  = 16;
  localparam int ID_W   = 16;
  localparam int STAT_W = 8;
  localparam logic [CNT_W-1:0] LOST     = '1;
  localparam int               SUM_MAX  = (1 << STAT_W) - 1;
  localparam int               RTT_ONES = (1 << (CNT_W + 1)) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              stats_clear = 1'b0;
  logic [15:0]       psize_req = 16'd0;
  logic [CNT_W-1:0]  delay_time = '0;
  logic [CNT_W-1:0]  timeout = '0;
  logic [31:0]       burst_len = '0;
  logic [15:0]       psize;
  logic              done;
  logic [CNT_W-1:0]  ping_time, pong_time;
  logic [STAT_W-1:0] ping_pongs_good, pings_lost, pongs_lost, rtt_sum;
  logic [CNT_W:0]    rtt_min, rtt_max;
  logic              burst_done, busy;

  eth_latency_coord_if #(.ID_W(ID_W)) lnk ();

  eth_latency_coord #(.CNT_W(CNT_W), .ID_W(ID_W), .STAT_W(STAT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .stats_clear     (stats_clear),
    .psize_req       (psize_req),
    .delay_time      (delay_time),
    .timeout         (timeout),
    .burst_len       (burst_len),
    .lnk             (lnk),
    .psize           (psize),
    .done            (done),
    .ping_time       (ping_time),
    .pong_time       (pong_time),
    .ping_pongs_good (ping_pongs_good),
    .pings_lost      (pings_lost),
    .pongs_lost      (pongs_lost),
    .rtt_min         (rtt_min),
    .rtt_max         (rtt_max),
    .rtt_sum         (rtt_sum),
    .burst_done      (burst_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  ping;
    logic [CNT_W-1:0]  pong;
    logic [STAT_W-1:0] good, pl, ql, sum;
    logic [CNT_W:0]    mn, mx;
    logic [ID_W-1:0]   id;
    logic [15:0]       psz;
    logic              hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Probe-level reference model state
  int              m_good, m_pl, m_ql, m_min, m_max, m_sum, m_burst;
  logic [ID_W-1:0] m_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  task automatic abort(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired waiting on DUT", what);
    summary();
    $fatal(1, "bench stopped early");
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_val(input int which);
    case (which)
      0:       return lnk.main_tx_trigger;
      1:       return lnk.loop_tx_trigger;
      default: return done;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, output int n);
    n = 0;
    while (!sig_val(which)) begin
      if (n >= bound) abort($sformatf("wait_sig%0d", which));
      tick();
      n++;
    end
  endtask

  task automatic model_clear();
    m_good = 0; m_pl = 0; m_ql = 0;
    m_min = RTT_ONES; m_max = 0; m_sum = 0;
  endtask

  // pk/qk: cycles from begin to the id match on each leg, 0 = never arrives.
  // exp_gap: expected cycles until the launch trigger, -1 = not checked.
  task automatic do_probe(input int pk, input int qk, input bit clr, input int exp_gap);
    int              n;
    int              rtt;
    exp_t            e;
    logic [ID_W-1:0] id_now;
    psize_req = 16'($urandom);
    wait_for(0, 5000, n);
    if (exp_gap >= 0) check("trigger_gap", 64'(n), 64'(exp_gap));
    check("busy_probe", 64'(busy), 64'd1);
    id_now = m_id;
    m_burst++;
    e.ping = (pk != 0) ? CNT_W'(pk) : LOST;
    e.pong = LOST;
    if (pk == 0) begin
      m_pl++;
    end else if (qk == 0) begin
      m_ql++;
      m_id = m_id + 1'b1;
    end else begin
      m_good++;
      rtt = pk + qk;
      if (rtt < m_min) m_min = rtt;
      if (rtt > m_max) m_max = rtt;
      m_sum = (m_sum + rtt > SUM_MAX) ? SUM_MAX : m_sum + rtt;
      m_id = m_id + 1'b1;
      e.pong = CNT_W'(qk);
    end
    if (clr) model_clear();
    e.good = STAT_W'(m_good);
    e.pl   = STAT_W'(m_pl);
    e.ql   = STAT_W'(m_ql);
    e.sum  = STAT_W'(m_sum);
    e.mn   = (CNT_W+1)'(m_min);
    e.mx   = (CNT_W+1)'(m_max);
    e.id   = m_id;
    e.psz  = psize_req;
    e.hold = (burst_len != 0) && (m_burst == int'(burst_len));
    exp_q.push_back(e);

    repeat ($urandom_range(0, 3)) tick();
    lnk.main_tx_begin = 1'b1;
    tick();
    lnk.main_tx_begin = 1'b0;
    if (pk != 0) begin
      repeat (pk - 1) tick();
      lnk.loop_rx_ping_id = id_now;
      wait_for(1, 5, n);
      repeat ($urandom_range(0, 3)) tick();
      lnk.loop_tx_begin = 1'b1;
      tick();
      lnk.loop_tx_begin = 1'b0;
      if (qk != 0) begin
        repeat (qk - 1) tick();
        lnk.main_rx_ping_id = id_now;
        if (clr) begin
          stats_clear = 1'b1;
          tick();
          stats_clear = 1'b0;
        end
      end
    end
    wait_for(2, int'(timeout) + 40, n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_psize"},      64'(psize), 64'd46);
    check({tag, "_ping_id"},    64'(lnk.ping_id), 64'd0);
    check({tag, "_main_trig"},  64'(lnk.main_tx_trigger), 64'd0);
    check({tag, "_loop_trig"},  64'(lnk.loop_tx_trigger), 64'd0);
    check({tag, "_done"},       64'(done), 64'd0);
    check({tag, "_busy"},       64'(busy), 64'd0);
    check({tag, "_burst_done"}, 64'(burst_done), 64'd0);
    check({tag, "_ping_time"},  64'(ping_time), 64'd0);
    check({tag, "_pong_time"},  64'(pong_time), 64'd0);
    check({tag, "_good"},       64'(ping_pongs_good), 64'd0);
    check({tag, "_pings_lost"}, 64'(pings_lost), 64'd0);
    check({tag, "_pongs_lost"}, 64'(pongs_lost), 64'd0);
    check({tag, "_rtt_min"},    64'(rtt_min), 64'(RTT_ONES));
    check({tag, "_rtt_max"},    64'(rtt_max), 64'd0);
    check({tag, "_rtt_sum"},    64'(rtt_sum), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no probe outstanding, required none");
      end else begin
        mon_e = exp_q.pop_front();
        check("ping_time",  64'(ping_time),       64'(mon_e.ping));
        check("pong_time",  64'(pong_time),       64'(mon_e.pong));
        check("good",       64'(ping_pongs_good), 64'(mon_e.good));
        check("pings_lost", 64'(pings_lost),      64'(mon_e.pl));
        check("pongs_lost", 64'(pongs_lost),      64'(mon_e.ql));
        check("rtt_min",    64'(rtt_min),         64'(mon_e.mn));
        check("rtt_max",    64'(rtt_max),         64'(mon_e.mx));
        check("rtt_sum",    64'(rtt_sum),         64'(mon_e.sum));
        check("ping_id",    64'(lnk.ping_id),     64'(mon_e.id));
        check("psize",      64'(psize),           64'(mon_e.psz));
        check("burst_done", 64'(burst_done),      64'(mon_e.hold));
      end
    end
  end

  initial begin
    #500000;
    abort("watchdog");
  end

  initial begin
    int n;
    lnk.main_tx_begin   = 1'b0;
    lnk.loop_tx_begin   = 1'b0;
    lnk.main_rx_ping_id = '1;
    lnk.loop_rx_ping_id = '1;
    m_id = '0;
    m_burst = 0;
    model_clear();

    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    delay_time = 10;
    timeout = 100;
    tick();
    enable = 1'b1;

    // Normal probe: 5 + 7
    do_probe(5, 7, 1'b0, 10);
    check("normal_ping", 64'(ping_time), 64'd5);
    check("normal_pong", 64'(pong_time), 64'd7);
    check("normal_sum",  64'(rtt_sum), 64'd12);
    check("normal_id",   64'(lnk.ping_id), 64'd1);

    // Lost ping with timeout 20
    timeout = 20;
    do_probe(0, 0, 1'b0, 11);
    check("lostping_cnt",  64'(pings_lost), 64'd1);
    check("lostping_id",   64'(lnk.ping_id), 64'd1);
    check("lostping_pong", 64'(pong_time), 64'(LOST));

    // Lost pong
    timeout = 100;
    do_probe(4, 0, 1'b0, 11);
    check("lostpong_cnt", 64'(pongs_lost), 64'd1);
    check("lostpong_id",  64'(lnk.ping_id), 64'd2);
    check("lostpong_sum", 64'(rtt_sum), 64'd12);

    // Statistics: rtts 12, 4, 30
    do_probe(2, 2, 1'b0, 11);
    do_probe(10, 20, 1'b0, 11);
    check("stats_min", 64'(rtt_min), 64'd4);
    check("stats_max", 64'(rtt_max), 64'd30);
    check("stats_sum", 64'(rtt_sum), 64'd46);

    // Clear coinciding with done
    do_probe(3, 3, 1'b1, 11);
    check("clr_good", 64'(ping_pongs_good), 64'd0);
    check("clr_min",  64'(rtt_min), 64'(RTT_ONES));
    check("clr_sum",  64'(rtt_sum), 64'd0);
    check("clr_ping", 64'(ping_time), 64'd3);

    // Burst of 3
    enable = 1'b0;
    tick();
    tick();
    m_burst = 0;
    burst_len = 3;
    delay_time = 4;
    enable = 1'b1;
    do_probe(1, 1, 1'b0, 4);
    do_probe(2, 1, 1'b0, 5);
    do_probe(1, 2, 1'b0, 5);
    n = 0;
    repeat (30) begin
      tick();
      if (lnk.main_tx_trigger) n++;
    end
    check("burst_no_trig",   64'(n), 64'd0);
    check("burst_hold",      64'(burst_done), 64'd1);
    check("burst_hold_busy", 64'(busy), 64'd0);
    enable = 1'b0;
    tick();
    check("burst_release", 64'(burst_done), 64'd0);
    m_burst = 0;
    burst_len = 0;
    enable = 1'b1;
    do_probe(2, 3, 1'b0, 4);

    // Saturation of the 8-bit rtt sum
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    model_clear();
    timeout = 150;
    do_probe(100, 100, 1'b0, -1);
    do_probe(100, 100, 1'b0, 5);
    check("sat_sum", 64'(rtt_sum), 64'd255);
    check("sat_max", 64'(rtt_max), 64'd200);

    // Randomized probes, including timeouts 0/1 and match-on-timeout
    for (int i = 0; i < 40; i++) begin
      int d, t, lim, pk, qk;
      bit clr;
      d   = $urandom_range(0, 5);
      t   = $urandom_range(0, 12);
      lim = (t < 1) ? 1 : t;
      delay_time = CNT_W'(d);
      timeout    = CNT_W'(t);
      pk  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, lim);
      qk  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, lim);
      clr = (pk != 0) && (qk != 0) && ($urandom_range(0, 5) == 0);
      do_probe(pk, qk, clr, d + 1);
    end

    // Reset in the middle of a probe
    psize_req = 16'h1234;
    wait_for(0, 100, n);
    tick();
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    enable = 1'b0;
    tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    summary();
    $finish;
  end

endmodule
